// File: rtl/adder_arb_pkg.sv
// Shared types and defaults for the two-requester shared-adder arbiter.
package adder_arb_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant_id = 1'b0;
        grant    = 2'b00;
        case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
        if (|valid) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/adder_share_arb.sv
// Two requesters share one WIDTH-bit adder through a round-robin arbiter and IDLE/ADD/RESP FSM.
// Define ADDER_SAT_EN to saturate rsp_sum to all-ones on carry-out.
module adder_share_arb
    import adder_arb_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_carry
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             last_grant_q;
    logic [1:0]       grant;
    logic             grant_id;
    logic             accept;
    logic [WIDTH:0]   sum_full;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    // The single shared adder, fed only from the latched operands.
    assign sum_full = (WIDTH+1)'(a_q) + (WIDTH+1)'(b_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Ready is only offered in IDLE, and only to the granted requester.
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = grant[0];
                req1_ready = grant[1];
                if (|grant) begin
                    accept  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_sum      <= '0;
            rsp_carry    <= 1'b0;
        end else begin
            rsp_valid <= (state_d == RESP);
            if (accept) begin
                a_q          <= grant_id ? req1_a : req0_a;
                b_q          <= grant_id ? req1_b : req0_b;
                id_q         <= grant_id;
                last_grant_q <= grant_id;
            end
            if (state_q == ADD) begin
                rsp_id    <= id_q;
                rsp_carry <= sum_full[WIDTH];
`ifdef ADDER_SAT_EN
                rsp_sum   <= sum_full[WIDTH] ? {WIDTH{1'b1}} : sum_full[WIDTH-1:0];
`else
                rsp_sum   <= sum_full[WIDTH-1:0];
`endif
            end
        end
    end

endmodule

// File: doc/adder_share_arb.md
ADDER_SHARE_ARB -- requirements
Module: adder_share_arb

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: req0_valid  input  1  requester 0 presents operands.
REQ-005 Port: req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-006 Port: req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 Port: req1_valid, req1_ready, req1_a, req1_b  same directions/widths/meaning as REQ-004..006, for requester 1.
REQ-008 Port: rsp_valid  output  1  result available.
REQ-009 Port: rsp_ready  input  1  consumer accepts result.
REQ-010 Port: rsp_id  output  1  requester that owns the result (0 or 1).
REQ-011 Port: rsp_sum  output  WIDTH  result of the shared adder.
REQ-012 Port: rsp_carry  output  1  carry-out of the unsaturated WIDTH-bit add.

Function
REQ-013 The block SHALL contain exactly one WIDTH-bit adder, shared by both requesters.
REQ-014 FSM states: IDLE, ADD, RESP; IDLE->ADD on grant, ADD->RESP unconditionally, RESP->IDLE when rsp_ready=1, otherwise RESP holds.
REQ-015 In IDLE, reqN_ready SHALL be 1 combinationally only for the granted requester and only when its valid=1; both readys 0 in ADD and RESP.
REQ-016 On the IDLE cycle with a grant, operands and grant id SHALL be latched; requester's data may change afterwards.
REQ-017 In ADD, {rsp_carry, sum} = a + b (WIDTH+1 bits) SHALL be registered.
REQ-018 rsp_valid=1 exactly in RESP; rsp_id/rsp_sum/rsp_carry stable throughout RESP.
REQ-019 Latency: handshake accept at cycle T -> rsp_valid=1 at T+2; minimum 3 cycles per transaction (rsp_ready held 1).
REQ-020 Arbitration round-robin: if only one valid, it wins; if both valid, winner is the requester not granted last.
REQ-021 last_grant SHALL update only on an accepted grant; idle cycles do not move it.
REQ-022 Wrap-around: 8'hFF + 8'h01 -> sum 8'h00, carry 1 (without REQ-027 macro).
REQ-023 A requester dropping valid in ADD/RESP SHALL have no effect on the in-flight transaction.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: state IDLE, rsp_valid 0, rsp_id 0, rsp_sum 0, rsp_carry 0, last_grant 1 (requester 0 wins first tie).
REQ-025 Reset mid-transaction SHALL discard the in-flight result; no response is issued for it.
REQ-026 After rst_n deasserts, arbitration SHALL resume on the first rising clk edge.

Configuration
REQ-027 Macro ADDER_SAT_EN: when defined, rsp_sum SHALL saturate to all-ones when carry=1 (rsp_carry still reports 1); when undefined, rsp_sum is the modulo-2^WIDTH sum.

Structure
REQ-028 Shared package adder_arb_pkg SHALL hold the FSM state enum (IDLE, ADD, RESP) and the default WIDTH constant.
REQ-029 The two-input round-robin grant logic SHALL be a sub-module rr_arb2 (inputs valid[1:0], last_grant; outputs grant one-hot, grant_id).

Verification
REQ-030 Single request: req0 a=8'h12 b=8'h34, rsp_ready=1 -> rsp_valid at T+2, id 0, sum 8'h46, carry 0.
REQ-031 Tie: both valid continuously after reset, rsp_ready=1 -> grants alternate 0,1,0,1; each result id matches its operands.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp outputs stable, both readys 0; release -> IDLE next cycle.
REQ-033 Overflow: a=8'hFF b=8'h02 -> carry 1, sum 8'h01 without ADDER_SAT_EN, 8'hFF with it.
REQ-034 Reset in ADD: rst_n low one cycle -> rsp_valid never asserts for that transaction; next tie grants requester 0.
REQ-035 Lone requester: only req1 valid for 4 transactions -> all granted to req1, no starvation stall, last_grant=1.
